// File: rtl/seg_display_pkg.sv
// Shared constants for the memory-mapped seven-segment display controller:
// segment code table, CTRL bit positions and register-select encoding.
package seg_display_pkg;

    // Active-low segment patterns for hex digits 0..F.
    localparam logic [7:0] SEG_HEX [16] = '{
        8'h81, 8'hcf, 8'h92, 8'h86, 8'hcc, 8'ha4, 8'ha0, 8'h8f,
        8'h80, 8'h84, 8'h88, 8'he0, 8'hb1, 8'hc2, 8'hb0, 8'hb8
    };

    localparam logic [7:0] SEG_BLANK = 8'hff;
    localparam logic [7:0] SEG_MINUS = 8'hfe;

    localparam int unsigned CTRL_SIGNED = 0;
    localparam int unsigned CTRL_LZB    = 1;
    localparam int unsigned CTRL_BLINK  = 2;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_DATA,
        SEL_CTRL
    } reg_sel_e;

    // Digit index width; a single-digit display still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_display_mmio_if.sv
// Bridge-bus slave port of the seven-segment display controller.
interface seg_display_mmio_if;
    logic [31:0] t_addr;
    logic        t_we;
    logic [31:0] t_wd;
    logic [31:0] disp_rd;

    modport master (output t_addr, output t_we, output t_wd, input disp_rd);
    modport slave  (input t_addr, input t_we, input t_wd, output disp_rd);
endinterface

// File: rtl/seg_display_mmio_seg_scan_timer.sv
// Scan timing: prescaler, modulo-NUM_DIGITS digit index and blink counter.
module seg_scan_timer
    import seg_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV_W = 10,
    parameter int unsigned BLINK_W    = 24
) (
    input  logic                                 clk,
    input  logic                                 clr_n,
    output logic [idx_width(NUM_DIGITS)-1:0]     digit_idx,
    output logic                                 blink_off
);

    localparam int unsigned IDX_W = idx_width(NUM_DIGITS);

    logic [SCAN_DIV_W-1:0] prescale;
    logic [BLINK_W-1:0]    blink_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            prescale  <= '0;
            blink_cnt <= '0;
            digit_idx <= '0;
        end else begin
            prescale  <= prescale + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            // Explicit wrap keeps non-power-of-2 digit counts in range.
            if (prescale == '1) begin
                if (digit_idx == IDX_W'(NUM_DIGITS - 1))
                    digit_idx <= '0;
                else
                    digit_idx <= digit_idx + 1'b1;
            end
        end
    end

    assign blink_off = blink_cnt[BLINK_W-1];

endmodule

// File: rtl/seg_display_mmio.sv
// Memory-mapped multiplexed seven-segment controller: DATA/CTRL registers,
// signed magnitude, leading-zero blanking, blinking and registered outputs.
module seg_display_mmio
    import seg_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV_W = 10,
    parameter int unsigned BLINK_W    = 24,
    parameter logic [31:0] BASE_ADDR  = 32'h7f38
) (
    input  logic                  clk,
    input  logic                  clr_n,
    seg_display_mmio_if.slave     bus,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            sign_seg
);

    localparam int unsigned IDX_W = idx_width(NUM_DIGITS);

    logic [31:0]      data_q;
    logic [2:0]       ctrl_q;
    reg_sel_e         sel;
    logic [IDX_W-1:0] digit_idx;
    logic             blink_off;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV_W (SCAN_DIV_W),
        .BLINK_W    (BLINK_W)
    ) u_timer (
        .clk       (clk),
        .clr_n     (clr_n),
        .digit_idx (digit_idx),
        .blink_off (blink_off)
    );

    always_comb begin
        sel = SEL_NONE;
        if (bus.t_addr >= BASE_ADDR && bus.t_addr <= BASE_ADDR + 32'd3)
            sel = SEL_DATA;
        else if (bus.t_addr >= BASE_ADDR + 32'd4 && bus.t_addr <= BASE_ADDR + 32'd7)
            sel = SEL_CTRL;
    end

    always_comb begin
        case (sel)
            SEL_DATA: bus.disp_rd = data_q;
            SEL_CTRL: bus.disp_rd = {29'b0, ctrl_q};
            default:  bus.disp_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else if (bus.t_we) begin
            if (sel == SEL_DATA)
                data_q <= bus.t_wd;
            else if (sel == SEL_CTRL)
                ctrl_q <= bus.t_wd[2:0];
        end
    end

    logic                  negative;
    logic [31:0]           mag;
    logic [IDX_W-1:0]      top_nz;
    logic [3:0]            nib;
    logic                  blank;
    logic [7:0]            seg_nx;
    logic [7:0]            sign_nx;
    logic [NUM_DIGITS-1:0] an_nx;

    always_comb begin
        negative = ctrl_q[CTRL_SIGNED] & data_q[31];
        mag      = negative ? (~data_q + 32'd1) : data_q;

        // Highest nonzero nibble among the displayed digits; 0 if all zero.
        top_nz = '0;
        nib    = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (mag[4*k +: 4] != 4'h0)
                top_nz = IDX_W'(k);
            if (digit_idx == IDX_W'(k))
                nib = mag[4*k +: 4];
        end

        blank  = ctrl_q[CTRL_LZB] && (digit_idx != '0) && (digit_idx > top_nz);
        seg_nx = blank ? SEG_BLANK : SEG_HEX[nib];

        an_nx = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++)
            an_nx[k] = !(ctrl_q[CTRL_BLINK] && blink_off) && (digit_idx == IDX_W'(k));

        sign_nx = (negative && !(ctrl_q[CTRL_BLINK] && blink_off)) ? SEG_MINUS : SEG_BLANK;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            seg      <= SEG_BLANK;
            an       <= '0;
            sign_seg <= SEG_BLANK;
        end else begin
            seg      <= seg_nx;
            an       <= an_nx;
            sign_seg <= sign_nx;
        end
    end

endmodule

// File: tb/tb_seg_display_mmio.sv
// Scoreboard bench: an 8-digit and a 5-digit instance on one shared bus,
// checked against a cycle-count based reference model.
module tb_seg_display_mmio;

    localparam logic [31:0] BASE = 32'h7f38;
    localparam int unsigned SCAN = 2;
    localparam int unsigned BW   = 4;

    logic        clk   = 1'b0;
    logic        clr_n = 1'b0;
    logic [31:0] addr  = BASE;
    logic [31:0] wd    = '0;
    logic        we    = 1'b0;

    always #5 clk = ~clk;

    seg_display_mmio_if bus8 ();
    seg_display_mmio_if bus5 ();
    assign bus8.t_addr = addr;
    assign bus8.t_we   = we;
    assign bus8.t_wd   = wd;
    assign bus5.t_addr = addr;
    assign bus5.t_we   = we;
    assign bus5.t_wd   = wd;

    logic [7:0] seg8, sign8, an8, seg5, sign5;
    logic [4:0] an5;

    seg_display_mmio #(.NUM_DIGITS(8), .SCAN_DIV_W(SCAN), .BLINK_W(BW), .BASE_ADDR(BASE)) u_dut8 (
        .clk(clk), .clr_n(clr_n), .bus(bus8.slave), .seg(seg8), .an(an8), .sign_seg(sign8)
    );
    seg_display_mmio #(.NUM_DIGITS(5), .SCAN_DIV_W(SCAN), .BLINK_W(BW), .BASE_ADDR(BASE)) u_dut5 (
        .clk(clk), .clr_n(clr_n), .bus(bus5.slave), .seg(seg5), .an(an5), .sign_seg(sign5)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] hex_tab [16] = '{
        8'h81, 8'hcf, 8'h92, 8'h86, 8'hcc, 8'ha4, 8'ha0, 8'h8f,
        8'h80, 8'h84, 8'h88, 8'he0, 8'hb1, 8'hc2, 8'hb0, 8'hb8
    };

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] an;
        logic [7:0] sign;
    } exp_t;

    exp_t        q8[$];
    exp_t        q5[$];
    logic [31:0] data_m;
    logic [2:0]  ctrl_m;
    int unsigned n_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected registered outputs after the n-th clock edge since reset.
    function automatic exp_t model_out(input int unsigned n, input logic [31:0] d,
                                       input logic [2:0] c, input int unsigned nd);
        exp_t        e;
        logic [31:0] mag;
        logic [3:0]  nib;
        int unsigned idx, top;
        bit          neg, blink, blank;
        neg   = c[0] && d[31];
        mag   = neg ? (32'd0 - d) : d;
        idx   = (n >> SCAN) % nd;
        blink = c[2] && (((n >> (BW - 1)) % 2) == 1);
        top   = 0;
        for (int k = 0; k < int'(nd); k++)
            if (((mag >> (4 * k)) & 32'hf) != 0) top = k;
        blank  = c[1] && idx > 0 && idx > top;
        nib    = 4'((mag >> (4 * idx)) & 32'hf);
        e.seg  = blank ? 8'hff : hex_tab[nib];
        e.an   = blink ? 8'h00 : 8'(1 << idx);
        e.sign = (neg && !blink) ? 8'hfe : 8'hff;
        return e;
    endfunction

    function automatic logic [31:0] read_m(input logic [31:0] a);
        if (a >= BASE && a <= BASE + 3) return data_m;
        if (a >= BASE + 4 && a <= BASE + 7) return {29'b0, ctrl_m};
        return 32'h0;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            n_m    = 0;
            data_m = '0;
            ctrl_m = '0;
            q8.delete();
            q5.delete();
        end else begin
            q8.push_back(model_out(n_m, data_m, ctrl_m, 8));
            q5.push_back(model_out(n_m, data_m, ctrl_m, 5));
            n_m++;
            if (we) begin
                if (addr >= BASE && addr <= BASE + 3) data_m = wd;
                else if (addr >= BASE + 4 && addr <= BASE + 7) ctrl_m = wd[2:0];
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!clr_n) begin
            check("rst_an8", 32'(an8), 32'h0);
            check("rst_seg8", 32'(seg8), 32'hff);
            check("rst_sign8", 32'(sign8), 32'hff);
            check("rst_an5", 32'(an5), 32'h0);
            check("rst_seg5", 32'(seg5), 32'hff);
        end else begin
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("seg8", 32'(seg8), 32'(e.seg));
                check("an8", 32'(an8), 32'(e.an));
                check("sign8", 32'(sign8), 32'(e.sign));
            end
            if (q5.size() > 0) begin
                e = q5.pop_front();
                check("seg5", 32'(seg5), 32'(e.seg));
                check("an5", 32'(an5), 32'(e.an));
                check("sign5", 32'(sign5), 32'(e.sign));
            end
        end
        check("disp_rd8", bus8.disp_rd, read_m(addr));
        check("disp_rd5", bus5.disp_rd, read_m(addr));
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        tick(1);
        we   = 1'b0;
        addr = BASE;
    endtask

    initial begin
        clr_n = 1'b0;
        tick(2);
        clr_n = 1'b1;
        tick(6);

        wr(BASE, 32'h1234abcd);
        wr(BASE + 4, 32'h0);
        tick(40);

        wr(BASE + 4, 32'h1);
        wr(BASE, 32'hffffffff);
        tick(40);
        wr(BASE, 32'h80000000);
        tick(40);

        wr(BASE + 4, 32'h2);
        wr(BASE, 32'h00000050);
        tick(40);
        wr(BASE, 32'h0);
        tick(40);

        wr(BASE + 4, 32'h4);
        wr(BASE, 32'h00c0ffee);
        tick(40);
        addr = BASE + 4;
        tick(2);
        wr(BASE + 8, 32'hdeadbeef);
        addr = BASE + 8;
        tick(2);
        addr = BASE;
        tick(2);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    addr = BASE + $urandom_range(0, 3);
                2, 3:    addr = BASE + $urandom_range(4, 7);
                4:       addr = BASE + $urandom_range(8, 12);
                default: addr = (BASE - 32'd1) ^ ($urandom_range(0, 1) ? 32'h0 : $urandom);
            endcase
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            tick(1);
            we = 1'b0;
            tick($urandom_range(0, 6));
        end

        wr(BASE + 4, 32'h3);
        wr(BASE, 32'h00012345);
        tick(7);
        @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        check("async_an8", 32'(an8), 32'h0);
        check("async_an5", 32'(an5), 32'h0);
        check("async_seg8", 32'(seg8), 32'hff);
        check("async_rd", bus8.disp_rd, 32'h0);
        tick(2);
        clr_n = 1'b1;
        tick(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
